// File: rtl/octo_button_reader.sv
// Eight-channel button reader: 2-flop sync, tick-based debounce, press/release pulses, event FIFO.
// Level/pulse latency 2 + DEBOUNCE_TICKS*TICK_DIV cycles max; events wait in pending bits while the FIFO is full.
module octo_evt_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  input  logic         rd_rdy
);
  // First-word fall-through; full flag from the registered count, so no push while full even on a pop.
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_wr, do_rd;

  assign wr_rdy = (count < FULL_CNT);
  assign rd_vld = (count != '0);
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;
  assign do_wr  = wr_vld & wr_rdy;
  assign do_rd  = rd_vld & rd_rdy;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module octo_button_reader #(
  parameter int TICK_DIV       = 25_000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] btn_i,
  output logic [7:0] level_o,
  output logic [7:0] press_o,
  output logic [7:0] release_o,
  output logic       evt_valid_o,
  output logic [3:0] evt_data_o,
  input  logic       evt_ready_i,
  output logic       overflow_o,
  input  logic       ovf_clr_i
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DEBOUNCE_TICKS);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_TICKS - 1);

  logic [7:0]    sync1, sync2;
  logic [PW-1:0] prescaler;
  logic          tick;
  logic [CW-1:0] cnt [8];
  logic [7:0]    level, press, rel;
  logic [15:0]   pend, pend_set, grant;
  logic          can_push, push_vld, ovf_set, overflow;
  logic [3:0]    push_dat;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_i;
      sync2 <= sync1;
    end
  end

  assign tick = (prescaler == PRE_MAX);

  always_ff @(posedge clk_i) begin
    if (rst_i)     prescaler <= '0;
    else if (tick) prescaler <= '0;
    else           prescaler <= prescaler + 1'b1;
  end

  // Any agreeing cycle restarts the count, so only a full run of mismatched ticks flips the level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level <= '0;
      press <= '0;
      rel   <= '0;
      for (int c = 0; c < 8; c++) cnt[c] <= '0;
    end else begin
      for (int c = 0; c < 8; c++) begin
        press[c] <= 1'b0;
        rel[c]   <= 1'b0;
        if (sync2[c] == level[c]) begin
          cnt[c] <= '0;
        end else if (tick) begin
          if (cnt[c] == CNT_MAX) begin
            cnt[c]   <= '0;
            level[c] <= sync2[c];
            press[c] <= sync2[c];
            rel[c]   <= ~sync2[c];
          end else begin
            cnt[c] <= cnt[c] + 1'b1;
          end
        end
      end
    end
  end

  // Bit index equals event code: presses 0..7 outrank releases 8..15; lowest set bit wins.
  assign pend_set = {rel, press};
  assign grant    = can_push ? (pend & (~pend + 16'd1)) : '0;
  assign push_vld = |grant;
  assign ovf_set  = |(pend_set & pend & ~grant);

  always_comb begin
    push_dat = '0;
    for (int e = 0; e < 16; e++) begin
      if (grant[e]) push_dat = 4'(e);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pend <= '0;
    else       pend <= (pend & ~grant) | pend_set;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)          overflow <= 1'b0;
    else if (ovf_set)   overflow <= 1'b1;
    else if (ovf_clr_i) overflow <= 1'b0;
  end

  octo_evt_fifo #(.W(4), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk_i),
    .rst    (rst_i),
    .wr_vld (push_vld),
    .wr_dat (push_dat),
    .wr_rdy (can_push),
    .rd_vld (evt_valid_o),
    .rd_dat (evt_data_o),
    .rd_rdy (evt_ready_i)
  );

  assign level_o    = level;
  assign press_o    = press;
  assign release_o  = rel;
  assign overflow_o = overflow;
endmodule

// File: tb/tb_octo_button_reader.sv
// Bench for octo_button_reader: cycle-level reference model plus directed scenarios with literal expectations.
module tb_octo_button_reader;
  localparam int TD = 4, DT = 3, FD = 4;

  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] btn = '0;
  logic       evt_ready = 1'b0, ovf_clr = 1'b0;
  logic [7:0] level, press, rel;
  logic       evt_valid, overflow;
  logic [3:0] evt_data;

  int total = 0, bad = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  octo_button_reader #(.TICK_DIV(TD), .DEBOUNCE_TICKS(DT), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk), .rst_i(rst), .btn_i(btn), .level_o(level), .press_o(press),
    .release_o(rel), .evt_valid_o(evt_valid), .evt_data_o(evt_data),
    .evt_ready_i(evt_ready), .overflow_o(overflow), .ovf_clr_i(ovf_clr)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: sync as a 2-deep history, tick from cycles since reset, run length of mismatched ticks.
  logic [7:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_prs = '0, m_rel = '0, m_pp = '0, m_pr = '0;
  logic       m_ovf = 1'b0;
  int         m_cyc = 0;
  int         m_run[8];
  logic [3:0] m_q[$];

  always @(posedge clk) begin : model
    bit         tick, lost;
    int         pick;
    logic [7:0] nprs, nrel;
    logic [15:0] pv;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0; m_pp = '0; m_pr = '0;
      m_ovf = 1'b0; m_cyc = 0; m_q.delete();
      for (int c = 0; c < 8; c++) m_run[c] = 0;
    end else begin
      tick = (m_cyc % TD) == TD - 1;
      pv = {m_pr, m_pp};
      pick = -1;
      if (m_q.size() < FD)
        for (int e = 15; e >= 0; e--) if (pv[e]) pick = e;
      if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
      if (pick >= 0) begin
        m_q.push_back(4'(pick));
        if (pick < 8) m_pp[pick] = 1'b0; else m_pr[pick-8] = 1'b0;
      end
      lost = (|(m_prs & m_pp)) || (|(m_rel & m_pr));
      m_pp = m_pp | m_prs;
      m_pr = m_pr | m_rel;
      if (lost) m_ovf = 1'b1; else if (ovf_clr) m_ovf = 1'b0;
      nprs = '0; nrel = '0;
      for (int c = 0; c < 8; c++) begin
        if (m_s2[c] == m_lvl[c]) m_run[c] = 0;
        else if (tick) begin
          m_run[c]++;
          if (m_run[c] == DT) begin
            m_run[c] = 0;
            m_lvl[c] = m_s2[c];
            if (m_s2[c]) nprs[c] = 1'b1; else nrel[c] = 1'b1;
          end
        end
      end
      m_prs = nprs; m_rel = nrel;
      m_s2 = m_s1; m_s1 = btn;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", level, m_lvl);
      chk("press", press, m_prs);
      chk("release", rel, m_rel);
      chk("evt_valid", evt_valid, m_q.size() > 0);
      chk("overflow", overflow, m_ovf);
      if (m_q.size() > 0) chk("evt_data", evt_data, m_q[0]);
    end
  end

  logic [3:0] got[$];
  int  press_cnt[8], rel_cnt[8], press_all_cnt;
  bit  seen_valid, seen_ovf;

  always @(negedge clk) begin
    if (chk_en) begin
      if (evt_valid && evt_ready) got.push_back(evt_data);
      for (int c = 0; c < 8; c++) begin
        if (press[c]) press_cnt[c]++;
        if (rel[c])   rel_cnt[c]++;
      end
      if (press == 8'hFF) press_all_cnt++;
      if (evt_valid) seen_valid = 1;
      if (overflow)  seen_ovf = 1;
    end
  end

  task automatic clear_mon();
    for (int c = 0; c < 8; c++) begin press_cnt[c] = 0; rel_cnt[c] = 0; end
    press_all_cnt = 0; seen_valid = 0; seen_ovf = 0;
    got.delete();
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_seq(input string nm, input int n, input logic [31:0] packed_exp);
    chk({nm, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      chk(nm, got[i], packed_exp[4*i +: 4]);
  endtask

  int lat;

  initial begin
    clear_mon();
    rst = 1'b1; btn = 8'hFF; evt_ready = 1'b1;
    @(posedge clk); #1;
    chk_en = 1;
    cyc(3);
    chk("rst_level", level, 0);
    chk("rst_press", press, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_ovf", overflow, 0);

    // Buttons held through reset: presses after the debounce delay, delivered 0..7.
    clear_mon();
    rst = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (lat < 0 && level == 8'hFF) lat = i;
    end
    chk("rst_rise_le15", (lat >= 1 && lat <= 15), 1);
    cyc(20);
    chk("press_all_once", press_all_cnt, 1);
    chk_seq("rst_events", 8, 32'h7654_3210);

    btn = 8'h00;
    cyc(35);

    // Clean step on channel 3.
    clear_mon();
    btn = 8'h08;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (lat < 0 && level[3]) lat = i;
    end
    chk("ch3_latency_ok", (lat >= 11 && lat <= 15), 1);
    cyc(10);
    chk("ch3_press_once", press_cnt[3], 1);
    chk_seq("ch3_press_evt", 1, 32'h3);
    clear_mon();
    btn = 8'h00;
    cyc(25);
    chk("ch3_rel_once", rel_cnt[3], 1);
    chk_seq("ch3_rel_evt", 1, 32'hB);

    // Bounce on channel 5, 3-cycle half period, never long enough to flip.
    clear_mon();
    for (int i = 0; i < 20; i++) begin
      btn[5] = ~btn[5];
      cyc(3);
    end
    cyc(20);
    chk("glitch_level", level, 0);
    chk("glitch_press", press_cnt[5], 0);
    chk("glitch_rel", rel_cnt[5], 0);
    chk("glitch_valid", seen_valid, 0);

    // Full FIFO with ready low, then merged duplicate press on channel 0.
    clear_mon();
    evt_ready = 1'b0;
    btn = 8'h1E; cyc(20);
    chk("full_head", evt_data, 1);
    btn = 8'h1F; cyc(20);
    btn = 8'h1E; cyc(20);
    chk("no_ovf_yet", overflow, 0);
    btn = 8'h1F; cyc(20);
    chk("ovf_set", overflow, 1);
    evt_ready = 1'b1;
    cyc(15);
    chk_seq("ovf_seq", 6, 32'h0080_4321);
    btn = 8'h00; cyc(30);
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // All channels at once with ready toggling every cycle.
    clear_mon();
    btn = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      evt_ready = ~evt_ready;
      cyc(1);
    end
    chk_seq("burst_seq", 8, 32'h7654_3210);
    chk("burst_ovf", overflow, 0);

    // Set beats clear in the same cycle; clear alone wins next.
    evt_ready = 1'b0;
    ovf_clr = 1'b1;
    btn = 8'h00; cyc(20);
    btn = 8'hFF; cyc(20);
    clear_mon();
    btn = 8'h00; cyc(20);
    chk("set_beats_clr", seen_ovf, 1);
    chk("clr_after_set", overflow, 0);
    ovf_clr = 1'b0;
    btn = 8'hFF; cyc(20);
    chk("ovf_again", overflow, 1);
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
    chk("clr_alone", overflow, 0);

    // Reset mid-operation discards queue; held buttons re-press afterwards.
    rst = 1'b1; cyc(2);
    chk("midrst_valid", evt_valid, 0);
    chk("midrst_level", level, 0);
    rst = 1'b0;
    clear_mon();
    evt_ready = 1'b1;
    cyc(30);
    chk("midrst_level_back", level, 8'hFF);
    chk_seq("midrst_events", 8, 32'h7654_3210);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
